// File: rtl/eth_rx_uart_sched_pkg.sv
// Shared types and constants for the Ethernet-to-UART byte scheduler.
package eth_uart_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'h55;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_HI,
    WAIT_LO
  } rd_state_t;
endpackage

// File: rtl/eth_rx_uart_sched_if.sv
// Receive-byte stream plus UART start/busy handshake between the Ethernet receiver and the UART.
interface eth_rx_uart_sched_if;
  import eth_uart_pkg::*;

  logic [BYTE_W-1:0] rx_data_in;
  logic              byte_rxdv;
  logic              frame_end;
  logic              frame_ok;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy;

  modport slave (
    input  rx_data_in, byte_rxdv, frame_end, frame_ok, tx_busy,
    output tx_data, tx_start
  );

  modport master (
    output rx_data_in, byte_rxdv, frame_end, frame_ok, tx_busy,
    input  tx_data, tx_start
  );
endinterface

// File: rtl/eth_rx_uart_sched_commit_fifo.sv
// Frame FIFO with a speculative write pointer: good frames commit, bad or overflowed frames roll back.
module eth_commit_fifo
  import eth_uart_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              frame_end,
  input  logic              frame_ok,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] head_data,
  output logic              head_first,
  output logic              nonempty,
  output logic              commit,
  output logic              drop,
  output logic [AW:0]       level
);
  logic [BYTE_W:0] mem [2**AW];
  logic [AW:0]     wr_ptr, cm_ptr, rd_ptr;
  logic [AW:0]     wr_next, cm_next, rd_next, used;
  logic            first_pend, ovf, full, do_wr, ovf_hit, ovf_eff, frame_has;

  assign used      = wr_ptr - rd_ptr;
  assign full      = used[AW];
  assign do_wr     = wr_en & ~full;
  assign ovf_hit   = wr_en & full;
  assign ovf_eff   = ovf | ovf_hit;
  assign wr_next   = wr_ptr + {{AW{1'b0}}, do_wr};
  // A same-cycle byte belongs to the ending frame, so it counts toward "frame has data".
  assign frame_has = (wr_ptr != cm_ptr) | do_wr;
  assign commit    = frame_end & frame_ok & ~ovf_eff & frame_has;
  assign drop      = frame_end & (~frame_ok | ovf_eff);
  assign cm_next   = commit ? wr_next : cm_ptr;
  assign rd_next   = rd_ptr + {{AW{1'b0}}, rd_en};

  assign nonempty   = (cm_ptr != rd_ptr);
  assign head_data  = mem[rd_ptr[AW-1:0]][BYTE_W-1:0];
  assign head_first = mem[rd_ptr[AW-1:0]][BYTE_W];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= {first_pend, wr_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      cm_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      ovf        <= 1'b0;
      first_pend <= 1'b1;
    end else begin
      wr_ptr <= drop ? cm_ptr : wr_next;
      cm_ptr <= cm_next;
      rd_ptr <= rd_next;
      level  <= cm_next - rd_next;
      if (frame_end)    ovf <= 1'b0;
      else if (ovf_hit) ovf <= 1'b1;
      if (frame_end)  first_pend <= 1'b1;
      else if (do_wr) first_pend <= 1'b0;
    end
  end
endmodule

// File: rtl/eth_rx_uart_sched.sv
// Drains committed Ethernet frame bytes to a UART one at a time; ETH_UART_SYNC_EN adds a marker byte per frame.
module eth_rx_uart_sched
  import eth_uart_pkg::*;
#(
  parameter int                AW        = 4,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic                    g_clk,
  input  logic                    reset,
  eth_rx_uart_sched_if.slave      bus,
  output logic [AW:0]             fifo_level,
  output logic [15:0]             frame_cnt,
  output logic [7:0]              drop_cnt
);
  rd_state_t         state_q, state_d;
  logic [BYTE_W-1:0] head_data;
  logic              head_first, nonempty, commit, drop, rd_en, use_sync;

  eth_commit_fifo #(.AW(AW)) u_fifo (
    .clk        (g_clk),
    .rst_n      (reset),
    .wr_en      (bus.byte_rxdv),
    .wr_data    (bus.rx_data_in),
    .frame_end  (bus.frame_end),
    .frame_ok   (bus.frame_ok),
    .rd_en      (rd_en),
    .head_data  (head_data),
    .head_first (head_first),
    .nonempty   (nonempty),
    .commit     (commit),
    .drop       (drop),
    .level      (fifo_level)
  );

`ifdef ETH_UART_SYNC_EN
  logic sync_sent_q;

  // Marker goes out once per frame, ahead of the entry flagged as the frame's first byte.
  assign use_sync = head_first & ~sync_sent_q;

  always_ff @(posedge g_clk) begin
    if (!reset)                 sync_sent_q <= 1'b0;
    else if (state_q == LOAD)   sync_sent_q <= use_sync;
  end
`else
  assign use_sync = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE:    if (nonempty && !bus.tx_busy) state_d = LOAD;
      LOAD: begin
        rd_en   = ~use_sync;
        state_d = START;
      end
      START:   state_d = WAIT_HI;
      WAIT_HI: if (bus.tx_busy) state_d = WAIT_LO;
      WAIT_LO: if (!bus.tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      bus.tx_data  <= '0;
      bus.tx_start <= 1'b0;
      frame_cnt    <= '0;
      drop_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      bus.tx_start <= (state_q == LOAD);
      if (state_q == LOAD) bus.tx_data <= use_sync ? SYNC_BYTE : head_data;
      if (commit) frame_cnt <= frame_cnt + 16'd1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_eth_rx_uart_sched.sv
// Directed bench for eth_rx_uart_sched (AW=2) with a 10-cycle busy UART model; honours ETH_UART_SYNC_EN.
module tb_eth_rx_uart_sched;
  localparam int AW = 2;

  logic          g_clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW:0]   fifo_level;
  logic [15:0]   frame_cnt;
  logic [7:0]    drop_cnt;
  int            vectors = 0;
  int            errors  = 0;
  int            start_while_busy = 0;
  int            busy_cnt = 0;
  logic [7:0]    cap [$];
  logic [7:0]    exp [$];
  int            chk_idx = 0;

  eth_rx_uart_sched_if bus ();

  eth_rx_uart_sched #(.AW(AW)) dut (
    .g_clk      (g_clk),
    .reset      (reset),
    .bus        (bus),
    .fifo_level (fifo_level),
    .frame_cnt  (frame_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 g_clk = ~g_clk;

  // UART model: busy rises the cycle after tx_start and stays high for 10 cycles.
  always @(posedge g_clk) begin
    if (!reset) begin
      bus.tx_busy <= 1'b0;
      busy_cnt    <= 0;
    end else if (bus.tx_start) begin
      if (bus.tx_busy) start_while_busy <= start_while_busy + 1;
      cap.push_back(bus.tx_data);
      bus.tx_busy <= 1'b1;
      busy_cnt    <= 10;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) bus.tx_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic put(input logic [7:0] b, input logic fe, input logic ok);
    @(negedge g_clk);
    bus.rx_data_in = b;
    bus.byte_rxdv  = 1'b1;
    bus.frame_end  = fe;
    bus.frame_ok   = ok;
    @(negedge g_clk);
    bus.byte_rxdv  = 1'b0;
    bus.frame_end  = 1'b0;
    bus.frame_ok   = 1'b0;
  endtask

  task automatic end_frame(input logic ok);
    @(negedge g_clk);
    bus.frame_end = 1'b1;
    bus.frame_ok  = ok;
    @(negedge g_clk);
    bus.frame_end = 1'b0;
    bus.frame_ok  = 1'b0;
  endtask

  task automatic exp_first(input logic [7:0] b);
`ifdef ETH_UART_SYNC_EN
    exp.push_back(8'h55);
`endif
    exp.push_back(b);
  endtask

  task automatic wait_cap(input string tag, input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (cap.size() >= n) break;
      @(negedge g_clk);
    end
    check({tag, "_timeout"}, 16'(cap.size() >= n), 16'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge g_clk);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 16'(cap.size()), 16'(exp.size()));
    for (int i = chk_idx; i < exp.size(); i++) begin
      if (i < cap.size()) check($sformatf("%s_byte%0d", tag, i), {8'h00, cap[i]}, {8'h00, exp[i]});
    end
    chk_idx = exp.size();
  endtask

  initial begin
    bus.rx_data_in = 8'h00;
    bus.byte_rxdv  = 1'b0;
    bus.frame_end  = 1'b0;
    bus.frame_ok   = 1'b0;
    idle(3);
    check("rst_level", {13'd0, fifo_level}, 16'd0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_drop_cnt", {8'h00, drop_cnt}, 16'd0);
    check("rst_tx_start", {15'd0, bus.tx_start}, 16'd0);
    check("rst_tx_data", {8'h00, bus.tx_data}, 16'd0);
    reset = 1'b1;
    idle(2);

    // 1: good frame 01 02 03
    put(8'h01, 1'b0, 1'b0);
    put(8'h02, 1'b0, 1'b0);
    put(8'h03, 1'b0, 1'b0);
    idle(3);
    check("pre_commit_no_tx", 16'(cap.size()), 16'd0);
    end_frame(1'b1);
    exp_first(8'h01); exp.push_back(8'h02); exp.push_back(8'h03);
    wait_cap("t1", exp.size(), 200);
    idle(20);
    check_stream("t1");
    check("t1_frame_cnt", frame_cnt, 16'd1);
    check("t1_level", {13'd0, fifo_level}, 16'd0);

    // 2: bad frame AA BB
    put(8'hAA, 1'b0, 1'b0);
    put(8'hBB, 1'b0, 1'b0);
    end_frame(1'b0);
    idle(30);
    check_stream("t2");
    check("t2_drop_cnt", {8'h00, drop_cnt}, 16'd1);
    check("t2_level", {13'd0, fifo_level}, 16'd0);
    check("t2_frame_cnt", frame_cnt, 16'd1);

    // empty good frame changes nothing
    end_frame(1'b1);
    idle(2);
    check("empty_frame_cnt", frame_cnt, 16'd1);
    check("empty_drop_cnt", {8'h00, drop_cnt}, 16'd1);

    // 3: 6-byte frame overflows a 4-entry FIFO, then a 2-byte frame
    for (int i = 0; i < 6; i++) put(8'h90 + 8'(i), 1'b0, 1'b0);
    end_frame(1'b1);
    idle(2);
    check("t3_drop_cnt", {8'h00, drop_cnt}, 16'd2);
    check("t3_level_after_rb", {13'd0, fifo_level}, 16'd0);
    check("t3_frame_cnt_rb", frame_cnt, 16'd1);
    put(8'hC1, 1'b0, 1'b0);
    put(8'hC2, 1'b0, 1'b0);
    end_frame(1'b1);
    exp_first(8'hC1); exp.push_back(8'hC2);
    wait_cap("t3", exp.size(), 200);
    idle(20);
    check_stream("t3");
    check("t3_frame_cnt", frame_cnt, 16'd2);

    // 4: single byte with frame_end in the same cycle
    put(8'h5A, 1'b1, 1'b1);
    exp_first(8'h5A);
    wait_cap("t4", exp.size(), 200);
    idle(20);
    check_stream("t4");
    check("t4_frame_cnt", frame_cnt, 16'd3);

    // 5: reset while the first byte of a 3-byte frame sits in WAIT_LO
    put(8'h71, 1'b0, 1'b0);
    put(8'h72, 1'b0, 1'b0);
    put(8'h73, 1'b1, 1'b1);
`ifdef ETH_UART_SYNC_EN
    exp.push_back(8'h55);
`else
    exp.push_back(8'h71);
`endif
    wait_cap("t5", exp.size(), 200);
    idle(3);
    reset = 1'b0;
    idle(2);
    check("t5_tx_start_rst", {15'd0, bus.tx_start}, 16'd0);
    check("t5_level_rst", {13'd0, fifo_level}, 16'd0);
    check("t5_frame_cnt_rst", frame_cnt, 16'd0);
    reset = 1'b1;
    idle(60);
    check_stream("t5");
    check("t5_level_after", {13'd0, fifo_level}, 16'd0);

    // 6: frames 11 / 22 33
    put(8'h11, 1'b1, 1'b1);
    put(8'h22, 1'b0, 1'b0);
    put(8'h33, 1'b1, 1'b1);
    exp_first(8'h11);
    exp_first(8'h22); exp.push_back(8'h33);
    wait_cap("t6", exp.size(), 300);
    idle(20);
    check_stream("t6");
    check("t6_frame_cnt", frame_cnt, 16'd2);

    // drop counter saturates at FF
    for (int i = 0; i < 260; i++) end_frame(1'b0);
    check("drop_sat", {8'h00, drop_cnt}, 16'h00FF);
    check("no_start_while_busy", 16'(start_while_busy), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
